// File: rtl/psram_dq_tx_if.sv
// ---------------------------------------------------------------------------
// psram_dq_tx_if
//   Write-word handshake between the PSRAM controller front end and the
//   DQ transmitter.
//
//   wdata  [15:0]  write word; [15:8] leaves on the rising edge, [7:0] on the
//                  falling edge
//   wmask  [1:0]   byte mask, 1 = masked; [1] pairs with wdata[15:8]
//   wvalid         wdata/wmask valid
//   wready         transmitter FIFO has room
//
//   master: word producer, slave: psram_dq_tx
// ---------------------------------------------------------------------------
interface psram_dq_tx_if;
  logic [15:0] wdata;
  logic [1:0]  wmask;
  logic        wvalid;
  logic        wready;

  modport master (output wdata, output wmask, output wvalid, input wready);
  modport slave  (input wdata, input wmask, input wvalid, output wready);
endinterface

// File: rtl/psram_dq_tx.sv
// ---------------------------------------------------------------------------
// psram_dq_tx
//   Write-side DQ transmitter. Buffers write words in a small FIFO and, after
//   a programmable latency, emits one word per clock as a rising/falling byte
//   pair for the DQ/RWDS ODDR cells, together with the output enable.
//
//   Ports
//     clk        system clock, shared with the ODDR cells
//     reset      synchronous, active-high
//     start      begin a burst (sampled only while idle)
//     burst_len  beats in burst minus 1 (sampled with start)
//     latency    idle cycles between start and first beat (sampled with start)
//     wr         write-word handshake (psram_dq_tx_if.slave)
//     dq_d0/d1   DQ byte for rising/falling edge
//     rwds_d0/d1 mask bit for rising/falling edge
//     dq_oe      drive enable for DQ and RWDS
//     busy       burst in progress (through the done cycle)
//     done       one-cycle pulse after the last beat
//     underrun   sticky underrun flag (only with PSRAM_DQ_TX_UNDERRUN_EN)
//
//   Parameter FIFO_DEPTH must be a power of two, >= 2.
//   Optional feature macro: PSRAM_DQ_TX_UNDERRUN_EN adds the underrun flag.
// ---------------------------------------------------------------------------
module psram_dq_tx #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [5:0]   burst_len,
  input  logic [3:0]   latency,
  psram_dq_tx_if.slave wr,
  output logic [7:0]   dq_d0,
  output logic [7:0]   dq_d1,
  output logic         rwds_d0,
  output logic         rwds_d1,
  output logic         dq_oe,
  output logic         busy,
`ifdef PSRAM_DQ_TX_UNDERRUN_EN
  output logic         underrun,
`endif
  output logic         done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LAT, S_DATA, S_DONE} state_t;

  // ---------------------------------------------------------------- FIFO
  // Entries hold {wmask, wdata}; the head is read combinationally so the
  // beat can be registered straight into the output flops.
  logic [17:0]           mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [FIFO_DEPTH-1:0] mem_we;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [17:0]           head_word;

  assign fifo_full  = (count_reg == DEPTH_CNT);
  assign fifo_empty = (count_reg == '0);
  assign wr.wready  = !fifo_full;
  assign push       = wr.wvalid && !fifo_full;
  assign head_word  = mem[rd_ptr_reg];

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_we
    assign mem_we[gi] = push && (wr_ptr_reg == PTR_W'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (mem_we[i]) begin
        mem[i] <= {wr.wmask, wr.wdata};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t      state_reg;
  state_t      state_next;
  logic [5:0]  bc_reg;
  logic [5:0]  bc_next;
  logic [3:0]  wc_reg;
  logic [3:0]  wc_next;

  logic [7:0]  dq_d0_reg;
  logic [7:0]  dq_d0_next;
  logic [7:0]  dq_d1_reg;
  logic [7:0]  dq_d1_next;
  logic        rwds_d0_reg;
  logic        rwds_d0_next;
  logic        rwds_d1_reg;
  logic        rwds_d1_next;
  logic        dq_oe_reg;
  logic        dq_oe_next;
  logic        busy_reg;
  logic        busy_next;
  logic        done_reg;
  logic        done_next;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      bc_reg      <= '0;
      wc_reg      <= '0;
      dq_d0_reg   <= '0;
      dq_d1_reg   <= '0;
      rwds_d0_reg <= 1'b0;
      rwds_d1_reg <= 1'b0;
      dq_oe_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bc_reg      <= bc_next;
      wc_reg      <= wc_next;
      dq_d0_reg   <= dq_d0_next;
      dq_d1_reg   <= dq_d1_next;
      rwds_d0_reg <= rwds_d0_next;
      rwds_d1_reg <= rwds_d1_next;
      dq_oe_reg   <= dq_oe_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_next = state_reg;
    bc_next    = bc_reg;
    wc_next    = wc_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          bc_next    = burst_len;
          wc_next    = latency;
          state_next = (latency != 4'd0) ? S_LAT : S_DATA;
        end
      end
      S_LAT: begin
        // wc starts at latency, so leaving on wc == 1 gives exactly
        // `latency` cycles in this state.
        wc_next = wc_reg - 4'd1;
        if (wc_reg == 4'd1) begin
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        bc_next = bc_reg - 6'd1;
        if (bc_reg == 6'd0) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output logic: values loaded into the output flops at the next edge
  always_comb begin
    pop          = 1'b0;
    dq_oe_next   = 1'b0;
    dq_d0_next   = 8'h00;
    dq_d1_next   = 8'h00;
    rwds_d0_next = 1'b0;
    rwds_d1_next = 1'b0;
    done_next    = 1'b0;
    // busy covers the whole burst plus the cycle carrying the done pulse.
    busy_next    = (state_next != S_IDLE) || (state_reg == S_DONE);
    case (state_reg)
      S_DATA: begin
        dq_oe_next = 1'b1;
        if (fifo_empty) begin
          // Underrun: fully masked beat; the burst keeps its length.
          rwds_d0_next = 1'b1;
          rwds_d1_next = 1'b1;
        end else begin
          pop          = 1'b1;
          dq_d0_next   = head_word[15:8];
          dq_d1_next   = head_word[7:0];
          rwds_d0_next = head_word[17];
          rwds_d1_next = head_word[16];
        end
      end
      S_DONE: begin
        done_next = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign dq_d0   = dq_d0_reg;
  assign dq_d1   = dq_d1_reg;
  assign rwds_d0 = rwds_d0_reg;
  assign rwds_d1 = rwds_d1_reg;
  assign dq_oe   = dq_oe_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

`ifdef PSRAM_DQ_TX_UNDERRUN_EN
  // Sticky; rises together with the first masked underrun beat on dq_*.
  logic underrun_reg;
  logic underrun_next;

  always_comb begin
    underrun_next = underrun_reg;
    if (state_reg == S_IDLE && start) begin
      underrun_next = 1'b0;
    end else if (state_reg == S_DATA && fifo_empty) begin
      underrun_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_reg <= 1'b0;
    end else begin
      underrun_reg <= underrun_next;
    end
  end

  assign underrun = underrun_reg;
`endif

endmodule

// File: tb/tb_psram_dq_tx.sv
module tb_psram_dq_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] burst_len;
  logic [3:0] latency;
  logic [7:0] dq_d0;
  logic [7:0] dq_d1;
  logic       rwds_d0;
  logic       rwds_d1;
  logic       dq_oe;
  logic       busy;
  logic       done;
`ifdef PSRAM_DQ_TX_UNDERRUN_EN
  logic       underrun;
`endif

  psram_dq_tx_if wr_if ();

  psram_dq_tx #(.FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .burst_len (burst_len),
    .latency   (latency),
    .wr        (wr_if),
    .dq_d0     (dq_d0),
    .dq_d1     (dq_d1),
    .rwds_d0   (rwds_d0),
    .rwds_d1   (rwds_d1),
    .dq_oe     (dq_oe),
    .busy      (busy),
`ifdef PSRAM_DQ_TX_UNDERRUN_EN
    .underrun  (underrun),
`endif
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Packed observation: {wready, dq_oe, dq_d0, dq_d1, rwds_d0, rwds_d1, busy, done}
  function automatic logic [21:0] ex(input logic wrdy, input logic oe,
                                     input logic [7:0] d0, input logic [7:0] d1,
                                     input logic r0, input logic r1,
                                     input logic bsy, input logic dn);
    return {wrdy, oe, d0, d1, r0, r1, bsy, dn};
  endfunction

  function automatic logic [21:0] obs();
    return {wr_if.wready, dq_oe, dq_d0, dq_d1, rwds_d0, rwds_d1, busy, done};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic [1:0] m);
    wr_if.wvalid = 1'b1;
    wr_if.wdata  = d;
    wr_if.wmask  = m;
    chk("push_wready", {31'd0, wr_if.wready}, 32'd1);
    step();
    wr_if.wvalid = 1'b0;
  endtask

  typedef struct {
    logic        rst;
    logic        st;
    logic [5:0]  bl;
    logic [3:0]  lat;
    logic        wv;
    logic [15:0] wd;
    logic [1:0]  wm;
    logic [21:0] e;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic st, input logic [5:0] bl,
                              input logic [3:0] lat, input logic wv,
                              input logic [15:0] wd, input logic [1:0] wm,
                              input logic [21:0] e);
    vec_t v;
    v.rst = rst; v.st = st; v.bl = bl; v.lat = lat;
    v.wv = wv; v.wd = wd; v.wm = wm; v.e = e;
    return v;
  endfunction

  vec_t        vecs [21];
  logic [17:0] words [64];
  logic [17:0] exp_q [$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [21:0] idle_e;
    logic [17:0] w;
    logic [21:0] e;
    int          pi;
    int          beats;
    logic        acc;
    logic        done_seen;

    reset = 1'b1; start = 1'b0; burst_len = '0; latency = '0;
    wr_if.wvalid = 1'b0; wr_if.wdata = '0; wr_if.wmask = '0;

    idle_e = ex(1, 0, 8'h00, 8'h00, 0, 0, 0, 0);

    // Inputs are applied before an edge; expectations are the outputs after it.
    for (int i = 0; i < 3; i++) vecs[i] = mk(1, 0, 0, 0, 0, 0, 0, idle_e);
    vecs[3]  = mk(0, 0, 0, 0, 0, 16'h0000, 2'b00, idle_e);
    vecs[4]  = mk(0, 0, 0, 0, 1, 16'h1234, 2'b00, idle_e);
    vecs[5]  = mk(0, 0, 0, 0, 1, 16'hABCD, 2'b01, ex(0, 0, 8'h00, 8'h00, 0, 0, 0, 0));
    vecs[6]  = mk(0, 1, 1, 0, 0, 0, 0,            ex(0, 0, 8'h00, 8'h00, 0, 0, 1, 0));
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0,            ex(1, 1, 8'h12, 8'h34, 0, 0, 1, 0));
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0,            ex(1, 1, 8'hAB, 8'hCD, 0, 1, 1, 0));
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0,            ex(1, 0, 8'h00, 8'h00, 0, 0, 1, 1));
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0,            idle_e);
    vecs[11] = mk(0, 0, 0, 0, 1, 16'h5AA5, 2'b00, idle_e);
    vecs[12] = mk(0, 1, 0, 5, 0, 0, 0,            ex(1, 0, 8'h00, 8'h00, 0, 0, 1, 0));
    for (int i = 13; i < 18; i++)
      vecs[i] = mk(0, 0, 0, 0, 0, 0, 0,           ex(1, 0, 8'h00, 8'h00, 0, 0, 1, 0));
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 0,            ex(1, 1, 8'h5A, 8'hA5, 0, 0, 1, 0));
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0,            ex(1, 0, 8'h00, 8'h00, 0, 0, 1, 1));
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 0,            idle_e);

    for (int i = 0; i < 21; i++) begin
      reset = vecs[i].rst; start = vecs[i].st;
      burst_len = vecs[i].bl; latency = vecs[i].lat;
      wr_if.wvalid = vecs[i].wv; wr_if.wdata = vecs[i].wd; wr_if.wmask = vecs[i].wm;
      step();
      chk($sformatf("vec%0d", i), {10'd0, obs()}, {10'd0, vecs[i].e});
    end
    reset = 1'b0; start = 1'b0; wr_if.wvalid = 1'b0;
    $display("table: %0d vectors done", 21);

    // ---- Underrun: 4 beats with only 2 words queued
    push(16'h1111, 2'b00);
    push(16'h2222, 2'b10);
    start = 1'b1; burst_len = 6'd3; latency = 4'd0;
    step();
    start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      step();
      case (b)
        0:       e = ex(1, 1, 8'h11, 8'h11, 0, 0, 1, 0);
        1:       e = ex(1, 1, 8'h22, 8'h22, 1, 0, 1, 0);
        default: e = ex(1, 1, 8'h00, 8'h00, 1, 1, 1, 0);
      endcase
      chk($sformatf("underrun_beat%0d", b + 1), {10'd0, obs()}, {10'd0, e});
`ifdef PSRAM_DQ_TX_UNDERRUN_EN
      chk($sformatf("underrun_flag%0d", b + 1), {31'd0, underrun}, (b >= 2) ? 32'd1 : 32'd0);
`endif
    end
    step();
    chk("underrun_done", {10'd0, obs()}, {10'd0, ex(1, 0, 8'h00, 8'h00, 0, 0, 1, 1)});
    step();
    chk("underrun_idle", {10'd0, obs()}, {10'd0, idle_e});
`ifdef PSRAM_DQ_TX_UNDERRUN_EN
    chk("underrun_sticky", {31'd0, underrun}, 32'd1);
`endif
    $display("underrun burst: 4 beats, 2 masked");

    // ---- Start during a running burst is ignored
    push(16'h3131, 2'b00);
    push(16'h4242, 2'b11);
    start = 1'b1; burst_len = 6'd1; latency = 4'd0;
    step();
    start = 1'b0;
`ifdef PSRAM_DQ_TX_UNDERRUN_EN
    chk("underrun_cleared", {31'd0, underrun}, 32'd0);
`endif
    step();
    chk("ign_beat1", {10'd0, obs()}, {10'd0, ex(1, 1, 8'h31, 8'h31, 0, 0, 1, 0)});
    start = 1'b1; burst_len = 6'd5;
    step();
    start = 1'b0;
    chk("ign_beat2", {10'd0, obs()}, {10'd0, ex(1, 1, 8'h42, 8'h42, 1, 1, 1, 0)});
    step();
    chk("ign_done", {10'd0, obs()}, {10'd0, ex(1, 0, 8'h00, 8'h00, 0, 0, 1, 1)});
    step();
    chk("ign_idle", {10'd0, obs()}, {10'd0, idle_e});
    $display("ignored start: burst kept 2 beats");

    // ---- Reset in beat 2 with a word still queued
    push(16'hC0DE, 2'b01);
    push(16'hFACE, 2'b10);
    start = 1'b1; burst_len = 6'd3; latency = 4'd0;
    step();
    start = 1'b0;
    wr_if.wvalid = 1'b1; wr_if.wdata = 16'h3333; wr_if.wmask = 2'b00;
    step();
    chk("rst_beat1", {10'd0, obs()}, {10'd0, ex(1, 1, 8'hC0, 8'hDE, 0, 1, 1, 0)});
    step();
    chk("rst_beat2", {10'd0, obs()}, {10'd0, ex(1, 1, 8'hFA, 8'hCE, 1, 0, 1, 0)});
    wr_if.wvalid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_applied", {10'd0, obs()}, {10'd0, idle_e});
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("rst_quiet%0d", k), {10'd0, obs()}, {10'd0, idle_e});
    end
    push(16'h7777, 2'b00);
    start = 1'b1; burst_len = 6'd0; latency = 4'd0;
    step();
    start = 1'b0;
    step();
    chk("rst_fresh_beat", {10'd0, obs()}, {10'd0, ex(1, 1, 8'h77, 8'h77, 0, 0, 1, 0)});
    step();
    chk("rst_fresh_done", {10'd0, obs()}, {10'd0, ex(1, 0, 8'h00, 8'h00, 0, 0, 1, 1)});
    step();
    $display("mid-burst reset: FIFO flushed, fresh burst ok");

    // ---- Streaming 64-word burst with continuous pushes
    for (int i = 0; i < 64; i++) words[i] = {2'($urandom), 16'($urandom)};
    exp_q.delete();
    pi = 0;
    for (int k = 0; k < 2; k++) begin
      wr_if.wvalid = 1'b1;
      {wr_if.wmask, wr_if.wdata} = words[pi];
      chk("stream_prefill", {31'd0, wr_if.wready}, 32'd1);
      step();
      exp_q.push_back(words[pi]);
      pi++;
    end
    wr_if.wvalid = 1'b0;
    chk("stream_full", {31'd0, wr_if.wready}, 32'd0);
    start = 1'b1; burst_len = 6'd63; latency = 4'd0;
    step();
    start = 1'b0;
    beats = 0;
    done_seen = 1'b0;
    for (int cyc = 0; cyc < 80 && !done_seen; cyc++) begin
      if (pi < 64) begin
        wr_if.wvalid = 1'b1;
        {wr_if.wmask, wr_if.wdata} = words[pi];
      end else begin
        wr_if.wvalid = 1'b0;
      end
      acc = wr_if.wvalid && wr_if.wready;
      step();
      if (acc) begin
        exp_q.push_back(words[pi]);
        pi++;
      end
      if (dq_oe) begin
        if (exp_q.size() > 0) w = exp_q.pop_front();
        else w = 18'h30000;
        chk($sformatf("stream_beat%0d", beats),
            {14'd0, rwds_d0, rwds_d1, dq_d0, dq_d1}, {14'd0, w});
        beats++;
      end
      if (done) done_seen = 1'b1;
    end
    wr_if.wvalid = 1'b0;
    chk("stream_beats", beats, 32'd64);
    chk("stream_done", {31'd0, done_seen}, 32'd1);
    chk("stream_pushed", pi, 32'd64);
    chk("stream_leftover", exp_q.size(), 32'd0);
    $display("streaming burst: %0d beats", beats);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/psram_dq_tx.md
Name: psram_dq_tx

Overview:
- Write-side DQ transmitter for the PSRAM controller. It is the output-direction counterpart of the capture path.
- Accepts 16-bit write words (data plus byte mask) on a valid/ready handshake and buffers them in a 2-entry FIFO.
- After a programmable latency, emits one word per clock as a rising/falling-edge byte pair (d0/d1) to the ODDR cells on DQ[7:0] and RWDS, and drives the output enable.

Parameters:
- FIFO_DEPTH, 2, write-word FIFO entries; must be a power of two, ≥2.

Ports:
- clk  in  1  system clock; the ODDR cells share it.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin burst; sampled only in IDLE.
- burst_len  in  6  words in burst minus 1 (0..63 → 1..64 words); sampled with start.
- latency  in  4  idle cycles between start and first beat (0..15); sampled with start.
- wdata  in  16  write word; [15:8] first (rising edge), [7:0] second.
- wmask  in  2  byte mask; 1 = masked; [1] pairs with wdata[15:8], [0] with wdata[7:0].
- wvalid  in  1  wdata/wmask valid.
- wready  out  1  FIFO not full.
- dq_d0  out  8  byte for ODDR rising edge.
- dq_d1  out  8  byte for ODDR falling edge.
- rwds_d0  out  1  mask bit for rising edge.
- rwds_d1  out  1  mask bit for falling edge.
- dq_oe  out  1  drive enable for DQ and RWDS.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse after the last beat.

Behaviour:
- Reset: clk and reset are as already decided — one clock, reset synchronous and active-high.
  - Reset values: all outputs 0 except wready = 1.
  - FIFO is emptied, state is IDLE, and both counters are 0.
- FIFO:
  - Push when wvalid && wready. wready = !full, registered-equivalent; it is independent of FSM state.
  - Pop only in DATA, one entry per cycle when not empty.
  - Simultaneous push and pop when full is not allowed, because wready = 0 then.
  - Push and pop in the same cycle keeps the count unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, LAT, DATA, DONE.
  - IDLE --start--> LAT if latency != 0, else DATA. On that edge latch burst_len into beat counter bc and latency into wait counter wc.
  - LAT: wc decrements each cycle. Move to DATA on the cycle wc reaches 1 (exactly `latency` cycles in LAT).
  - DATA: each cycle emits one beat and decrements bc. Move to DONE after the beat with bc == 0, giving burst_len+1 beats.
  - DONE: one cycle, then IDLE.
  - start is ignored outside IDLE.
- Outputs are registered, so a beat decided in DATA cycle n appears on dq_* in cycle n+1.
- Timing: start sampled at edge E.
  - busy = 1 from E+1 through the done cycle inclusive.
  - dq_oe = 1 for exactly burst_len+1 consecutive cycles, with the first beat visible at E+latency+2.
  - done = 1 the cycle after the last beat, with dq_oe = 0 in that cycle.
- Beat content:
  - dq_d0 = head[15:8], dq_d1 = head[7:0].
  - rwds_d0 = mask[1], rwds_d1 = mask[0].
- Idle outputs: when dq_oe = 0, dq_d0/dq_d1 = 0 and rwds = 0.
- Empty FIFO in DATA (underrun): emit a masked beat — dq = 0x00/0x00, rwds = 1/1. The beat still counts toward burst_len, so the burst never stalls.
- Leftover FIFO words after DONE remain queued for the next burst.
- Reset mid-burst: at the next edge all outputs return to reset values, FIFO is cleared, state is IDLE, and no done pulse is issued.

Optional Feature:
- Macro: PSRAM_DQ_TX_UNDERRUN_EN.
- Defined:
  - Adds output port `underrun` (1 bit).
  - Sticky flag, set in the same cycle the masked underrun beat appears on dq_*.
  - Cleared on reset or on an accepted start.
- Undefined:
  - No port and no flag logic.
  - Underrun beats are still emitted masked exactly as described in Behaviour.

Test Plan:
- Reset then idle:
  - Stimulus: reset 3 cycles, release.
  - Response: wready = 1; dq_oe = busy = done = 0; dq_d0 = dq_d1 = 0x00.
- Basic burst with latency 0:
  - Stimulus: preload 0x1234/mask 0 and 0xABCD/mask 2'b01; start with burst_len = 1, latency = 0 at edge E.
  - Response at E+2: dq_d0/d1 = 0x12/0x34, rwds 0/0.
  - Response at E+3: 0xAB/0xCD, rwds 0/1.
  - Response at E+4: done = 1, dq_oe = 0.
- Latency count:
  - Stimulus: latency = 5, burst_len = 0, FIFO holds 0x5AA5.
  - Response: dq_oe high only at E+7 with 0x5A/0xA5; busy high E+1..E+8.
- Underrun:
  - Stimulus: burst_len = 3 with only 2 words queued.
  - Response: beats 3 and 4 are 0x00/0x00 with rwds 1/1; done still after 4 beats.
  - With PSRAM_DQ_TX_UNDERRUN_EN: underrun rises with beat 3 and clears on the next start.
- Backpressure and streaming:
  - Stimulus: push continuously during a 64-word burst (burst_len = 63).
  - Response: wready drops when FIFO holds 2 entries; no word lost or duplicated; output sequence equals input sequence.
- Reset mid-burst and ignored start:
  - Stimulus: assert start again at E+3 of a running burst.
  - Response: start ignored, beat count unchanged.
  - Stimulus: assert reset in beat 2.
  - Response: next cycle dq_oe = 0, busy = 0, wready = 1, no done; a new burst then outputs only freshly pushed words.
